// File: rtl/vector_sequencer.sv
// vector_sequencer
//   Steps a VEC_W-bit data vector (and optionally a CTRL_W-bit control word)
//   through every value, holding each vector for at least HOLD cycles and
//   advancing only when the downstream side accepts it.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : begin a sweep (sampled in IDLE only)
//   sweep_ctrl : 1 = also sweep the control word (sampled with start)
//   ctrl_in    : initial control word (sampled with start)
//   pause      : freeze counter and outputs while high
//   ready      : downstream accepts the current vector
//   vec_out    : current data vector
//   ctrl_out   : current control word
//   valid      : vec_out/ctrl_out form a live test vector
//   busy       : sweep in progress
//   done       : one-cycle pulse at sweep completion
module vector_sequencer #(
    parameter int VEC_W  = 9,
    parameter int CTRL_W = 4,
    parameter int HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sweep_ctrl,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              pause,
    input  logic              ready,
    output logic [VEC_W-1:0]  vec_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [7:0] HOLD_MAX = 8'(HOLD - 1);

    state_t            state, state_nx;
    logic [VEC_W-1:0]  vec_nx;
    logic [CTRL_W-1:0] ctrl_nx;
    logic [7:0]        hold_cnt, hold_nx;
    logic              sweep_lat, sweep_nx;
    logic              valid_nx, busy_nx, done_nx;
    logic              accept, vec_last, ctrl_last;

    // pause wins over ready: a paused cycle never accepts
    assign accept    = (state == RUN) && !pause && ready && (hold_cnt == HOLD_MAX);
    assign vec_last  = &vec_out;
    assign ctrl_last = &ctrl_out;

    always_comb begin
        state_nx = state;
        vec_nx   = vec_out;
        ctrl_nx  = ctrl_out;
        hold_nx  = hold_cnt;
        sweep_nx = sweep_lat;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    vec_nx   = '0;
                    ctrl_nx  = ctrl_in;
                    hold_nx  = '0;
                    sweep_nx = sweep_ctrl;
                end
            end
            RUN: begin
                if (accept) begin
                    hold_nx = '0;
                    // last vector: stop unless the control word still has room to step
                    if (vec_last && (!sweep_lat || ctrl_last)) begin
                        state_nx = FIN;
                    end else begin
                        vec_nx = vec_out + 1'b1;
                        if (vec_last) ctrl_nx = ctrl_out + 1'b1;
                    end
                end else if (!pause && hold_cnt != HOLD_MAX) begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // status flags are registered copies of the next state
        valid_nx = (state_nx == RUN);
        busy_nx  = (state_nx == RUN);
        done_nx  = (state_nx == FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec_out   <= '0;
            ctrl_out  <= '0;
            hold_cnt  <= '0;
            sweep_lat <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            vec_out   <= vec_nx;
            ctrl_out  <= ctrl_nx;
            hold_cnt  <= hold_nx;
            sweep_lat <= sweep_nx;
            valid     <= valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer
//   Two instances: u_a with default parameters, u_b with VEC_W=2, CTRL_W=2,
//   HOLD=3. Expected vectors are queued when a sweep is started and popped
//   each time a new vector appears on the outputs.
module tb_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, sweep_a, pause_a, ready_a;
    logic [3:0] ctrl_in_a, ctrl_a;
    logic [8:0] vec_a;
    logic       valid_a, busy_a, done_a;

    logic       rst_b, start_b, sweep_b, pause_b, ready_b;
    logic [1:0] ctrl_in_b, ctrl_b;
    logic [1:0] vec_b;
    logic       valid_b, busy_b, done_b;

    vector_sequencer u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .sweep_ctrl(sweep_a),
        .ctrl_in(ctrl_in_a), .pause(pause_a), .ready(ready_a),
        .vec_out(vec_a), .ctrl_out(ctrl_a), .valid(valid_a), .busy(busy_a), .done(done_a)
    );

    vector_sequencer #(.VEC_W(2), .CTRL_W(2), .HOLD(3)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .sweep_ctrl(sweep_b),
        .ctrl_in(ctrl_in_b), .pause(pause_b), .ready(ready_b),
        .vec_out(vec_b), .ctrl_out(ctrl_b), .valid(valid_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    logic [12:0] q0[$];
    logic [12:0] q1[$];
    int          held[2];
    bit          acc[2];
    bit          vprev[2];
    logic [12:0] exp_cur[2];
    int          dones[2];
    int          runc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // before the edge: will the vector on display be taken at this edge?
    task automatic predict(input int id, input logic vld, input logic rdy, input logic pse,
                           input int hold);
        acc[id] = vld && rdy && !pse && (held[id] == hold - 1);
        if (vld && !pse)
            held[id] = acc[id] ? 0 : ((held[id] < hold - 1) ? held[id] + 1 : held[id]);
    endtask

    // after the edge: compare a freshly shown vector against the queue head
    task automatic observe(input int id, input logic [3:0] c, input logic [8:0] v,
                           input logic vld, input logic dn);
        logic [12:0] obs;
        int          sz;
        obs = {c, v};
        sz  = (id == 0) ? q0.size() : q1.size();
        if (vld && (acc[id] || !vprev[id])) begin
            chk($sformatf("queue_has_%0d", id), (sz > 0) ? 1 : 0, 1);
            if (sz > 0) begin
                exp_cur[id] = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("vector_%0d", id), obs, exp_cur[id]);
            end
            held[id] = 0;
        end else if (vld) begin
            chk($sformatf("stable_%0d", id), obs, exp_cur[id]);
        end
        if (acc[id] && !vld) begin
            chk($sformatf("done_at_end_%0d", id), dn, 1);
            chk($sformatf("queue_empty_%0d", id), sz, 0);
        end
        if (dn) dones[id]++;
        if (vld) runc[id]++;
        vprev[id] = vld;
        acc[id]   = 1'b0;
    endtask

    task automatic tick();
        predict(0, valid_a, ready_a, pause_a, 1);
        predict(1, valid_b, ready_b, pause_b, 3);
        @(posedge clk);
        @(negedge clk);
        observe(0, ctrl_a, vec_a, valid_a, done_a);
        observe(1, {2'b00, ctrl_b}, {7'b0, vec_b}, valid_b, done_b);
    endtask

    task automatic wait_done(input int id, input int budget);
        int d0;
        int n;
        d0 = dones[id];
        n  = 0;
        while (dones[id] == d0 && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("done_seen_%0d", id), dones[id] - d0, 1);
    endtask

    task automatic push_a(input logic [3:0] c);
        for (int i = 0; i < 512; i++) q0.push_back({c, 9'(i)});
    endtask

    initial begin
        int d0;
        int n;
        for (int i = 0; i < 2; i++) begin
            held[i] = 0; acc[i] = 0; vprev[i] = 0; exp_cur[i] = '0; dones[i] = 0; runc[i] = 0;
        end
        rst_a = 1; start_a = 0; sweep_a = 0; pause_a = 0; ready_a = 1; ctrl_in_a = 4'h0;
        rst_b = 1; start_b = 0; sweep_b = 0; pause_b = 0; ready_b = 1; ctrl_in_b = 2'b00;
        tick();
        chk("rst_vec_a", vec_a, 0);
        chk("rst_ctrl_a", ctrl_a, 0);
        chk("rst_flags_a", {valid_a, busy_a, done_a}, 0);
        chk("rst_flags_b", {valid_b, busy_b, done_b, vec_b, ctrl_b}, 0);
        rst_a = 0; rst_b = 0;
        tick();
        chk("idle_a", {valid_a, busy_a, done_a}, 0);

        // full sweep of the default instance, fixed control word
        ctrl_in_a = 4'b0101; sweep_a = 0; ready_a = 1; pause_a = 0;
        push_a(4'b0101);
        runc[0] = 0;
        start_a = 1;
        tick();
        start_a = 0;
        chk("busy_a", {valid_a, busy_a}, 2'b11);
        wait_done(0, 600);
        chk("run_len_a", runc[0], 512);
        chk("fin_flags_a", {valid_a, busy_a}, 0);
        chk("fin_hold_a", {ctrl_a, vec_a}, {4'b0101, 9'h1ff});
        tick();
        chk("post_fin_a", {valid_a, busy_a, done_a}, 0);
        tick();
        chk("idle_hold_a", {ctrl_a, vec_a}, {4'b0101, 9'h1ff});

        // small instance sweeping the control word, random ready and pause
        ctrl_in_b = 2'b10; sweep_b = 1;
        for (int c = 2; c < 4; c++)
            for (int v = 0; v < 4; v++) q1.push_back({4'(c), 9'(v)});
        start_b = 1;
        tick();
        start_b = 0;
        d0 = dones[1];
        n  = 0;
        while (dones[1] == d0 && n < 400) begin
            ready_b = 1'($urandom_range(0, 1));
            pause_b = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        chk("done_seen_b", dones[1] - d0, 1);
        chk("fin_hold_b", {ctrl_b, vec_b}, 4'b1111);
        ready_b = 1; pause_b = 0;
        tick();
        chk("post_fin_b", {valid_b, busy_b, done_b}, 0);

        // pause at 37, then reset mid-sweep at 200
        ctrl_in_a = 4'h3;
        push_a(4'h3);
        start_a = 1;
        tick();
        start_a = 0;
        for (int i = 0; i < 100 && vec_a != 9'd37; i++) tick();
        chk("reach_37", vec_a, 37);
        pause_a = 1;
        for (int i = 0; i < 10; i++) begin
            ready_a = 1'($urandom_range(0, 1));
            tick();
            chk("paused_37", vec_a, 37);
        end
        pause_a = 0; ready_a = 1;
        tick();
        chk("resume_38", vec_a, 38);
        for (int i = 0; i < 300 && vec_a != 9'd200; i++) tick();
        chk("reach_200", vec_a, 200);
        d0 = dones[0];
        #2 rst_a = 1;
        #1;
        chk("async_rst_a", {ctrl_a, vec_a, valid_a, busy_a, done_a}, 0);
        q0.delete();
        held[0] = 0; acc[0] = 0; vprev[0] = 0;
        tick();
        rst_a = 0;
        tick();
        tick();
        chk("no_done_on_abort", dones[0], d0);
        chk("idle_after_rst", {valid_a, vec_a}, 0);
        ctrl_in_a = 4'h9;
        push_a(4'h9);
        start_a = 1;
        tick();
        start_a = 0;
        wait_done(0, 600);

        // start held high: next sweep starts only after FIN and one IDLE cycle
        ctrl_in_b = 2'b01; sweep_b = 0;
        for (int v = 0; v < 4; v++) q1.push_back({4'h1, 9'(v)});
        start_b = 1;
        tick();
        wait_done(1, 40);
        tick();
        chk("idle_gap_b", {valid_b, busy_b, done_b}, 0);
        for (int v = 0; v < 4; v++) q1.push_back({4'h1, 9'(v)});
        tick();
        chk("restart_b", {valid_b, vec_b}, 3'b100);
        start_b = 0;
        wait_done(1, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter VEC_W, default 9: width of the data vector driven to the downstream OR circuit (inputs a..i, a = bit 0).
REQ-002 SHALL have parameter CTRL_W, default 4: width of the control-pin word (in1..in4, in1 = bit 0).
REQ-003 SHALL have parameter HOLD, default 1, legal range 1..255: clock cycles each vector is held before it may advance.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: begin a sweep (sampled in IDLE only).
REQ-007 SHALL have port sweep_ctrl, input, 1 bit: 1 = also sweep control word; 0 = fixed control word (sampled with start).
REQ-008 SHALL have port ctrl_in, input, CTRL_W bits: initial control word (sampled with start).
REQ-009 SHALL have port pause, input, 1 bit: freeze the sweep while high.
REQ-010 SHALL have port ready, input, 1 bit: downstream accepts the current vector.
REQ-011 SHALL have port vec_out, output, VEC_W bits: current data vector.
REQ-012 SHALL have port ctrl_out, output, CTRL_W bits: current control word.
REQ-013 SHALL have port valid, output, 1 bit: vec_out/ctrl_out are a live test vector.
REQ-014 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at sweep completion.

Function
REQ-016 SHALL implement states IDLE, RUN, FIN; all outputs registered.
REQ-017 In IDLE with start=1, next cycle SHALL be RUN with vec_out=0, ctrl_out=ctrl_in, hold counter=0, sweep_ctrl latched.
REQ-018 In IDLE, start=0 SHALL leave state and outputs unchanged; start in RUN/FIN SHALL be ignored.
REQ-019 In RUN, valid=1 and busy=1.
REQ-020 In RUN, the hold counter SHALL increment each cycle with pause=0, saturating at HOLD-1; pause=1 SHALL freeze the counter and the outputs.
REQ-021 A vector SHALL be accepted on a cycle with pause=0, ready=1, and hold counter = HOLD-1. On acceptance, the hold counter SHALL clear and vec_out SHALL increment by 1, modulo 2^VEC_W.
REQ-022 When ready=0, vec_out SHALL stay stable; no vector SHALL be skipped or repeated on the downstream side.
REQ-023 On acceptance of vec_out = all-ones with latched sweep_ctrl=0, next state SHALL be FIN.
REQ-024 On acceptance of vec_out = all-ones with sweep_ctrl=1:
- if ctrl_out is not all-ones: vec_out SHALL wrap to 0 and ctrl_out SHALL increment.
- if ctrl_out is all-ones: next state SHALL be FIN.
REQ-025 In FIN, done=1, valid=0, busy=0 for exactly one cycle; vec_out and ctrl_out SHALL hold their last values; next state SHALL be IDLE.
REQ-026 In IDLE, valid=0, busy=0, done=0.
REQ-027 Sweep length with sweep_ctrl=0 and ready=1, pause=0 throughout SHALL be 2^VEC_W*HOLD RUN cycles.
REQ-028 pause and ready=0 on the same cycle SHALL behave as pause.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, vec_out=0, ctrl_out=0, valid=0, busy=0, done=0, hold counter=0, latched sweep_ctrl=0, independent of clk.
REQ-030 rst asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after release SHALL begin a fresh sweep from vec_out=0.

Verification
REQ-031 Defaults, ctrl_in=4'b0101, sweep_ctrl=0, ready=1, pause=0, start pulse -> valid for 512 cycles, vec_out 0..511 in order, ctrl_out=0101 constant, then one done pulse, then IDLE.
REQ-032 VEC_W=2, CTRL_W=2, sweep_ctrl=1, ctrl_in=2'b10 -> (ctrl,vec) sequence 10/00..10/11, then 11/00..11/11, then done; 8 vectors total.
REQ-033 HOLD=3, ready toggled randomly -> each vector visible for at least 3 cycles; vectors advance only on cycles with ready=1; no vector lost or duplicated.
REQ-034 pause=1 for 10 cycles at vec_out=37 -> vec_out stays 37 and hold counter frozen; sweep resumes at 38 after release.
REQ-035 rst pulsed between clock edges at vec_out=200 -> outputs zero immediately, no done pulse; a new start begins at vec_out=0.
REQ-036 start held high continuously -> a new sweep begins only on the cycle after FIN; start during RUN has no effect.
